// File: rtl/clk_div_mon_pkg.sv
// clk_div_mon_pkg: FSM encodings and constants shared by the divider monitor
package clk_div_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_EDGE = 2'd1, MEASURE = 2'd2, LOCKED = 2'd3} state_t;
  localparam int LOCK_CNT_DEF = 4;
  localparam int TO_MULT = 2;
endpackage

// File: rtl/clk_div_edge_det.sv
// clk_div_edge_det: samples the divided clock and flags its rising edge
// CLK_DIV_MON_SYNC_EN inserts a 2-flop synchronizer ahead of the sample register
module clk_div_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic s,
  output logic rise
);
  logic q, s_d;
`ifdef CLK_DIV_MON_SYNC_EN
  logic [1:0] sy;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sy <= '0;
    else sy <= {sy[0], d};
  assign q = sy[1];
`else
  assign q = d;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {s, s_d} <= '0;
    else {s, s_d} <= {q, s};
  assign rise = s & ~s_d;
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of a divided clock, checks them against div_exp, tracks lock and errors
// CLK_DIV_MON_SYNC_EN allows clk_div_in from an unrelated clock (adds 2 cycles of latency)
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_div_in,
  input  logic             en,
  input  logic [DIV_W-1:0] div_exp,
  input  logic             clr_cnt,
  output logic             lock,
  output logic             err,
  output logic             timeout,
  output logic             cfg_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [DIV_W:0]   period_meas,
  output logic [DIV_W:0]   high_meas
);
  localparam int CW = DIV_W + 1;
  state_t st, st_n;
  logic [3:0] good, good_n;
  logic [CW-1:0] cnt, hcnt, per_exp, hi_exp, to_lim;
  logic s, rise, bad, act, match, ev, lock_n, to_n;
  clk_div_edge_det u_edge (.clk(clk), .rstn(rstn), .d(clk_div_in), .s(s), .rise(rise));
  assign per_exp = {1'b0, div_exp};
  assign hi_exp = CW'(div_exp >> 1);
  assign to_lim = CW'(per_exp * TO_MULT);
  assign bad = div_exp < DIV_W'(2);
  assign act = en && !bad && (st == MEASURE || st == LOCKED);
  assign match = cnt == per_exp && hcnt == hi_exp;
  always_comb begin
    st_n = st;
    good_n = good;
    lock_n = lock;
    to_n = timeout;
    ev = 1'b0;
    if (!en || bad) begin
      st_n = IDLE;
      good_n = '0;
      lock_n = 1'b0;
      to_n = 1'b0;
    end else if (st == IDLE) st_n = WAIT_EDGE;
    else if (st == WAIT_EDGE) begin
      if (rise) begin
        st_n = MEASURE;
        good_n = '0;
        to_n = 1'b0;
      end
    end else if (rise && match) begin
      good_n = st == LOCKED ? good : good + 4'd1;
      lock_n = good_n == 4'(LOCK_CNT);
      st_n = lock_n ? LOCKED : MEASURE;
    end else if (rise || cnt >= to_lim) begin
      // a stall drops back to edge search; a bad period restarts counting
      ev = 1'b1;
      good_n = '0;
      lock_n = 1'b0;
      st_n = rise ? MEASURE : WAIT_EDGE;
      to_n = !rise;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st <= IDLE;
      good <= '0;
      lock <= 1'b0;
      timeout <= 1'b0;
      err <= 1'b0;
      cfg_err <= 1'b0;
      cnt <= '0;
      hcnt <= '0;
      err_cnt <= '0;
      period_meas <= '0;
      high_meas <= '0;
    end else begin
      st <= st_n;
      good <= good_n;
      lock <= lock_n;
      timeout <= to_n;
      err <= ev;
      cfg_err <= en && bad;
      cnt <= st == IDLE ? '0 : rise ? CW'(1) : &cnt ? cnt : cnt + CW'(1);
      hcnt <= st == IDLE ? '0 : rise ? CW'(1) : (s && !(&hcnt)) ? hcnt + CW'(1) : hcnt;
      err_cnt <= clr_cnt ? ERR_W'(ev) : err_cnt + ERR_W'(ev && !(&err_cnt));
      if (rise && act) begin
        period_meas <= cnt;
        high_meas <= hcnt;
      end
    end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Checker stage directly downstream of the even clock divider.
- Samples the divided clock in the source clock domain and measures its period and high time in source-clock cycles.
- Compares both against the programmed ratio, declares lock after consecutive good periods, and flags/counts deviations and stalls.
- Used in silicon as a divider health monitor and in simulation as a self-checking consumer of clk_div.

Parameters:
- DIV_W, 8: width of div_exp and of the measurement outputs.
- LOCK_CNT, 4: consecutive matching periods required to assert lock (range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  source clock; the same clock that drives the divider.
- rstn  input  1  asynchronous active-low reset.
- clk_div_in  input  1  divided clock under test.
- en  input  1  monitor enable.
- div_exp  input  DIV_W  expected division ratio; held quasi-static while en=1.
- clr_cnt  input  1  synchronous clear of err_cnt.
- lock  output  1  ratio confirmed.
- err  output  1  one-cycle pulse per mismatch or timeout.
- timeout  output  1  sticky; set on stall, cleared on next rising edge or when en=0.
- cfg_err  output  1  div_exp < 2 while en=1.
- err_cnt  output  ERR_W  saturating mismatch count.
- period_meas  output  DIV_W+1  last measured period.
- high_meas  output  DIV_W+1  last measured high time.

Behaviour:
- Reset: all outputs and internal state are 0; FSM is in IDLE.
- Sampling and edge detection:
  - s = clk_div_in registered once; s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- Expected values: hi_exp = div_exp >> 1; per_exp = div_exp, zero-extended to DIV_W+1 bits.
- Counters:
  - On rise: cnt loads 1 and hcnt loads 1.
  - Otherwise: cnt increments each cycle; hcnt increments only while s=1.
  - Both saturate at all-ones.
- On each rise after the first, the period result is p = cnt and the high result is h = hcnt (values before reload).
  - period_meas and high_meas register p and h one cycle after the rise cycle.
  - End-to-end: outputs update 2 clk cycles after the clk edge on which clk_div_in rose.
- FSM states:
  - IDLE: entered when en=0; counters cleared; lock=0.
  - WAIT_EDGE: entered on en=1 with div_exp >= 2. On the first rise, go to MEASURE with good=0; no compare on this edge.
  - MEASURE: on each rise, compare (p == per_exp && h == hi_exp).
    - Match: good++. When good reaches LOCK_CNT, go to LOCKED and assert lock in the same registered update.
    - Mismatch: good=0, err pulse, err_cnt++.
  - LOCKED: on match, stay. On mismatch, lock=0, err pulse, err_cnt++, go to MEASURE with good=0.
- Timeout:
  - Applies in MEASURE and LOCKED only.
  - If cnt reaches 2*per_exp with no rise: err pulse, timeout=1, lock=0, err_cnt++, go to WAIT_EDGE.
- cfg_err:
  - en=1 and div_exp < 2 gives cfg_err=1; the FSM is held in IDLE.
  - cfg_err clears the cycle after div_exp becomes legal or en drops.
- en deasserted mid-operation: go to IDLE next cycle; lock=0 and timeout=0. err_cnt and the *_meas outputs retain their values.
- err_cnt:
  - Saturates at 2^ERR_W-1.
  - clr_cnt alone: err_cnt becomes 0.
  - clr_cnt coinciding with an error event: err_cnt becomes 1.
- An asynchronous reset at any time returns all state to the reset values immediately.

Optional Feature:
- CLK_DIV_MON_SYNC_EN
  - Defined: a 2-flop synchronizer is inserted ahead of s, so clk_div_in may come from an unrelated clock. Latency grows by 2 cycles, to 4 cycles from input edge to *_meas update. Comparison rules are unchanged.
  - Undefined: single sample register only; clk_div_in must be synchronous to clk.

Decomposition:
- Shared package/header clk_div_mon_pkg holds:
  - FSM state encodings (IDLE=0, WAIT_EDGE=1, MEASURE=2, LOCKED=3);
  - the LOCK_CNT default;
  - the timeout multiplier constant (2).
- Sub-module clk_div_edge_det: optional synchronizer, sample register, and rise/fall detection. The parent holds the counters and FSM.

Test Plan:
- Lock: clk period 4 ns, clean /4 input, en=1, div_exp=4 → period_meas=4 and high_meas=2 on each update; lock=1 after the 4th compared rise (5th rise overall); err=0.
- Ratio change: while locked, switch input to /6 → at the next rise err pulses for 1 cycle, lock=0, err_cnt=1; period_meas=6, high_meas=3; err_cnt increments once per period thereafter.
- Stall: while locked, hold clk_div_in=0 → exactly 8 cycles after the last rise: err pulse, timeout=1, lock=0, state WAIT_EDGE. Restoring /4 clears timeout on the first rise; lock returns after 4 good periods.
- Config: en=1, div_exp=1 → cfg_err=1, lock never asserts, err never pulses. Setting div_exp=4 clears cfg_err the next cycle and acquisition proceeds.
- Counter: drive err_cnt to 255 (saturation holds at 255). clr_cnt alone → 0. clr_cnt in the same cycle as a mismatch → 1.
- Reset/enable: drop en mid-MEASURE → lock=0 next cycle, err_cnt retained. Assert rstn=0 while LOCKED → all outputs 0 immediately.
